gsim_residual: RTL and testbench

GSIM_RESIDUAL -- requirements
Module: gsim_residual

---
 rtl/gsim_pkg.sv | 38 +++
 rtl/gsim_band_mac.sv | 20 ++
 rtl/gsim_residual.sv | 150 +++++++++++++++
 tb/tb_gsim_residual.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// rtl/gsim_pkg.sv - shared sizes, band coefficients, FSM states and shift-add helper for gsim_residual
package gsim_pkg;

  localparam int N     = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = IDX_W + 1;
  localparam int B_W   = 16;
  localparam int X_W   = 32;
  localparam int R_W   = 40;
  localparam int FRAC  = 16;

  localparam int COEF_0 = 20;
  localparam int COEF_1 = -13;
  localparam int COEF_2 = 6;
  localparam int COEF_3 = -1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_COMPUTE,
    ST_DONE
  } state_t;

  // Constant coefficient unrolls into shifted copies of x; no multiplier is built.
  function automatic logic signed [R_W-1:0] mul_coef(input logic signed [X_W-1:0] x, input int c);
    logic signed [R_W-1:0] xe;
    logic signed [R_W-1:0] acc;
    int                    m;
    xe  = {{(R_W-X_W){x[X_W-1]}}, x};
    acc = '0;
    m   = (c < 0) ? -c : c;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) acc = acc + (xe <<< k);
    end
    return (c < 0) ? -acc : acc;
  endfunction

endpackage

// File: rtl/gsim_band_mac.sv
// rtl/gsim_band_mac.sv - combinational 7-tap banded row sum (A*x)_j using shift-add products
module gsim_band_mac
  import gsim_pkg::*;
(
  input  logic signed [X_W-1:0] xm3_i,
  input  logic signed [X_W-1:0] xm2_i,
  input  logic signed [X_W-1:0] xm1_i,
  input  logic signed [X_W-1:0] x0_i,
  input  logic signed [X_W-1:0] xp1_i,
  input  logic signed [X_W-1:0] xp2_i,
  input  logic signed [X_W-1:0] xp3_i,
  output logic signed [R_W-1:0] sum_o
);

  assign sum_o = mul_coef(x0_i,  COEF_0)
               + mul_coef(xm1_i, COEF_1) + mul_coef(xp1_i, COEF_1)
               + mul_coef(xm2_i, COEF_2) + mul_coef(xp2_i, COEF_2)
               + mul_coef(xm3_i, COEF_3) + mul_coef(xp3_i, COEF_3);

endmodule

// File: rtl/gsim_residual.sv
// rtl/gsim_residual.sv - streams residual r = A*x - b for a 16-element banded system
// Optional GSIM_RESID_MAX_EN adds res_max, the running max |r_j| of the frame.
module gsim_residual
  import gsim_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           in_en,
  input  logic [B_W-1:0] b_in,
  input  logic           x_valid,
  input  logic [X_W-1:0] x_in,
  output logic           r_valid,
  output logic [R_W-1:0] r_out,
  output logic           done
`ifdef GSIM_RESID_MAX_EN
  ,
  output logic [R_W-1:0] res_max
`endif
);

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        b_cnt_q, b_cnt_d;
  logic [CNT_W-1:0]        x_cnt_q, x_cnt_d;
  logic [CNT_W-1:0]        j_q, j_d;
  logic signed [B_W-1:0]   b_buf [N];
  logic signed [X_W-1:0]   x_buf [N];
  logic                    collecting, b_take, x_take, emit, counts_full;
  logic signed [X_W-1:0]   tap [7];
  logic signed [CNT_W+1:0] tap_idx;
  logic signed [B_W-1:0]   b_j;
  logic signed [R_W-1:0]   b_shift, mac_sum, r_d;
  logic                    r_valid_q;
  logic [R_W-1:0]          r_out_q;

  assign counts_full = (b_cnt_q == N_CNT) && (x_cnt_q == N_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (in_en || x_valid) state_d = ST_COLLECT;
      ST_COLLECT: if (counts_full) state_d = ST_COMPUTE;
      ST_COMPUTE: if (j_q == N_CNT) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    collecting = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
    b_take     = collecting && in_en && (b_cnt_q < N_CNT);
    x_take     = collecting && x_valid && (x_cnt_q < N_CNT);
    emit       = (state_q == ST_COMPUTE) && (j_q < N_CNT);
    done       = (state_q == ST_DONE);
  end

  always_comb begin
    b_cnt_d = b_cnt_q;
    x_cnt_d = x_cnt_q;
    j_d     = '0;
    if (state_q == ST_DONE) begin
      b_cnt_d = '0;
      x_cnt_d = '0;
    end else begin
      if (b_take) b_cnt_d = b_cnt_q + 1'b1;
      if (x_take) x_cnt_d = x_cnt_q + 1'b1;
    end
    if (state_q == ST_COMPUTE) j_d = emit ? j_q + 1'b1 : j_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_cnt_q <= '0;
      x_cnt_q <= '0;
      j_q     <= '0;
    end else begin
      b_cnt_q <= b_cnt_d;
      x_cnt_q <= x_cnt_d;
      j_q     <= j_d;
    end
  end

  // Buffers keep stale data across reset; the counters alone gate what is used.
  always_ff @(posedge clk) begin
    if (b_take) b_buf[b_cnt_q[IDX_W-1:0]] <= b_in;
    if (x_take) x_buf[x_cnt_q[IDX_W-1:0]] <= x_in;
  end

  always_comb begin
    tap_idx = '0;
    for (int t = 0; t < 7; t++) begin
      tap_idx = $signed({2'b00, j_q}) + (CNT_W+2)'(t - 3);
      tap[t]  = (!tap_idx[CNT_W+1] && (tap_idx < (CNT_W+2)'(N))) ? x_buf[tap_idx[IDX_W-1:0]] : '0;
    end
  end

  gsim_band_mac u_mac (
    .xm3_i (tap[0]),
    .xm2_i (tap[1]),
    .xm1_i (tap[2]),
    .x0_i  (tap[3]),
    .xp1_i (tap[4]),
    .xp2_i (tap[5]),
    .xp3_i (tap[6]),
    .sum_o (mac_sum)
  );

  always_comb begin
    b_j     = b_buf[j_q[IDX_W-1:0]];
    b_shift = {{(R_W-B_W-FRAC){b_j[B_W-1]}}, b_j, {FRAC{1'b0}}};
    r_d     = emit ? (mac_sum - b_shift) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_q <= 1'b0;
      r_out_q   <= '0;
    end else begin
      r_valid_q <= emit;
      r_out_q   <= r_d;
    end
  end

  assign r_valid = r_valid_q;
  assign r_out   = r_out_q;

`ifdef GSIM_RESID_MAX_EN
  logic [R_W-1:0] res_max_q, res_max_d, r_abs;

  always_comb begin
    r_abs     = r_out_q[R_W-1] ? (~r_out_q + 1'b1) : r_out_q;
    res_max_d = res_max_q;
    if (state_q == ST_IDLE)                    res_max_d = '0;
    else if (r_valid_q && (r_abs > res_max_q)) res_max_d = r_abs;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) res_max_q <= '0;
    else       res_max_q <= res_max_d;
  end

  assign res_max = res_max_q;
`endif

endmodule

// File: tb/tb_gsim_residual.sv
// tb/tb_gsim_residual.sv - scoreboard bench for gsim_residual (define GSIM_RESID_MAX_EN to check res_max)
module tb_gsim_residual;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_en;
  logic [15:0] b_in;
  logic        x_valid;
  logic [31:0] x_in;
  logic        r_valid;
  logic [39:0] r_out;
  logic        done;
`ifdef GSIM_RESID_MAX_EN
  logic [39:0] res_max;
`endif

  int          tests    = 0;
  int          fails    = 0;
  int          done_cnt = 0;
  int          done_exp = 0;
  logic [39:0] exp_q [$];
  logic [39:0] exp_r;
  logic [15:0] bv [16];
  logic [31:0] xv [16];
  logic [39:0] ev [16];
  logic [39:0] t2_exp [16];
  logic [39:0] exp_max;

  always #5 clk = ~clk;

  gsim_residual dut (
    .clk     (clk),
    .reset   (reset),
    .in_en   (in_en),
    .b_in    (b_in),
    .x_valid (x_valid),
    .x_in    (x_in),
    .r_valid (r_valid),
    .r_out   (r_out),
    .done    (done)
`ifdef GSIM_RESID_MAX_EN
    ,
    .res_max (res_max)
`endif
  );

  always @(negedge clk) begin
    if (!reset) begin
      tests++;
      if (r_valid) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_r_valid: r_out=%h, required no residual", r_out);
        end else begin
          exp_r = exp_q.pop_front();
          if (r_out !== exp_r) begin
            fails++;
            $display("FAIL residual: r_out=%h, required %h", r_out, exp_r);
          end
        end
      end else if (r_out !== 40'd0) begin
        fails++;
        $display("FAIL r_out_idle: r_out=%h, required 0", r_out);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic send_frame(input int extra_b, input int extra_x);
    int last;
    last = 16 + ((extra_b > extra_x) ? extra_b : extra_x);
    for (int i = 0; i < 16; i++) exp_q.push_back(ev[i]);
    for (int i = 0; i < last; i++) begin
      @(posedge clk); #1;
      in_en   = (i < 16 + extra_b);
      x_valid = (i < 16 + extra_x);
      b_in    = (i < 16) ? bv[i] : 16'h7fff;
      x_in    = (i < 16) ? xv[i] : 32'h7fff0000;
    end
    @(posedge clk); #1;
    in_en   = 1'b0;
    x_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 100);
    check("done_seen", {39'd0, done}, 40'd1);
`ifdef GSIM_RESID_MAX_EN
    check("res_max", res_max, exp_max);
`endif
    done_exp++;
    repeat (3) @(negedge clk);
    check("queue_drained", 40'(exp_q.size()), 40'd0);
    check("done_once", 40'(done_cnt), 40'(done_exp));
  endtask

  initial begin
    int seen;
    int n;
    reset   = 1'b1;
    in_en   = 1'b0;
    x_valid = 1'b0;
    b_in    = '0;
    x_in    = '0;
    for (int j = 0; j < 16; j++) begin
      if (j == 0 || j == 15)      t2_exp[j] = 40'h00000C0000;
      else if (j == 1 || j == 14) t2_exp[j] = 40'hFFFFFF0000;
      else if (j == 2 || j == 13) t2_exp[j] = 40'h0000050000;
      else                        t2_exp[j] = 40'h0000040000;
    end
    #1;
    check("reset_r_valid", {39'd0, r_valid}, 40'd0);
    check("reset_r_out", r_out, 40'd0);
    check("reset_done", {39'd0, done}, 40'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // all zeros, plus first-residual latency
    for (int j = 0; j < 16; j++) begin
      bv[j] = '0; xv[j] = '0; ev[j] = '0;
    end
    exp_max = 40'd0;
    send_frame(0, 0);
    @(negedge clk); check("lat_cycle1", {39'd0, r_valid}, 40'd0);
    @(negedge clk); check("lat_cycle2", {39'd0, r_valid}, 40'd0);
    @(negedge clk); check("lat_first", {39'd0, r_valid}, 40'd1);
    wait_done();

    // x = 1.0 everywhere, b = 0
    for (int j = 0; j < 16; j++) begin
      bv[j] = '0; xv[j] = 32'h00010000; ev[j] = t2_exp[j];
    end
    exp_max = 40'h00000C0000;
    send_frame(0, 0);
    wait_done();

    // reset after the 5th residual
    send_frame(0, 0);
    seen = 0;
    n    = 0;
    while (seen < 5 && n < 100) begin
      @(negedge clk);
      n++;
      if (r_valid === 1'b1) seen++;
    end
    check("five_seen", 40'(seen), 40'd5);
    #1 reset = 1'b1;
    #1;
    check("midrst_r_valid", {39'd0, r_valid}, 40'd0);
    check("midrst_r_out", r_out, 40'd0);
    check("midrst_done", {39'd0, done}, 40'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (30) @(negedge clk);

    // x = 0, b_j = j+1
    for (int j = 0; j < 16; j++) begin
      bv[j] = 16'(j + 1); xv[j] = '0; ev[j] = -(40'(j + 1) << 16);
    end
    exp_max = 40'h0000100000;
    send_frame(0, 0);
    wait_done();

    // 18 in_en pulses and x_valid during COMPUTE are ignored
    for (int j = 0; j < 16; j++) begin
      bv[j] = 16'(j); xv[j] = 32'h00010000; ev[j] = t2_exp[j] - (40'(j) << 16);
    end
    exp_max = 40'h00000F0000;
    send_frame(2, 10);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
